key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of decoded key channels (1..16).
REQ-002 Parameter KC_SLOTS, default 4: number of 8-bit keycode slots in the keycode input (1..6).
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a button change (>=1).
REQ-004 Parameter REPEAT_DELAY, default 500000: held cycles before the first repeat; 0 disables repeat.
REQ-005 Parameter REPEAT_RATE, default 100000: cycles between subsequent repeats (>=1).
REQ-006 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 keycode  in  8*KC_SLOTS  USB HID keycodes; slot j is bits [8j+7:8j].
REQ-009 key_map  in  8*NUM_KEYS  keycode assigned to channel i at bits [8i+7:8i]; 8'h00 means no keyboard mapping; held static in operation.
REQ-010 KEY  in  NUM_KEYS  asynchronous active-low pushbuttons, one per channel.
REQ-011 btn_en  in  NUM_KEYS  per-channel button enable; 0 ignores KEY[i].
REQ-012 key_on  out  NUM_KEYS  level: channel i is currently held.
REQ-013 key_press  out  NUM_KEYS  one-cycle pulse on press.
REQ-014 key_release  out  NUM_KEYS  one-cycle pulse on release.
REQ-015 key_repeat  out  NUM_KEYS  one-cycle auto-repeat pulse while held.

Function
REQ-016 kc_hit[i] SHALL be 1 when any slot equals key_map[i] and key_map[i] != 8'h00, and SHALL be registered once (one cycle of latency).
REQ-017 KEY[i] SHALL pass through a 2-flop synchroniser, then a debouncer: counter clears whenever the synchronised value equals btn_stable[i], and btn_stable[i] takes the synchronised value on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-018 btn_stable[i] SHALL reset to "released"; btn_hit[i] = btn_stable[i] pressed AND btn_en[i].
REQ-019 key_on[i] SHALL be registered kc_hit[i] OR btn_hit[i]; keyboard and button pressed together count as one press.
REQ-020 Each channel FSM SHALL have the states IDLE, HELD and REPEAT, plus a per-channel counter wide enough for max(REPEAT_DELAY, REPEAT_RATE).
REQ-021 IDLE with key_on=1: key_press pulses the next cycle, the FSM moves to HELD, and the counter clears.
REQ-022 HELD or REPEAT with key_on=0: key_release pulses the next cycle, the FSM moves to IDLE, and the counter clears; release takes priority over a repeat due in the same cycle.
REQ-023 HELD: when the counter reaches REPEAT_DELAY-1, key_repeat pulses, the FSM moves to REPEAT, and the counter clears; otherwise the counter increments. With REPEAT_DELAY=0 the FSM stays in HELD and the counter holds.
REQ-024 REPEAT: when the counter reaches REPEAT_RATE-1, key_repeat pulses and the counter clears; otherwise the counter increments.
REQ-025 A one-cycle key_on glitch SHALL produce exactly one press followed by one release, on consecutive cycles.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels all pulse in the same cycle.
REQ-027 Duplicate key_map values SHALL drive every matching channel.
REQ-028 The three pulse outputs are mutually exclusive per channel per cycle.

Reset
REQ-029 While Reset_n=0: all outputs, synchronisers (held at released level), debounce counters and repeat counters SHALL be 0/released and every FSM in IDLE.
REQ-030 A key held through reset deassertion SHALL produce a fresh key_press once key_on asserts; no release is emitted for activity before reset.
REQ-031 Reset asserted mid-repeat SHALL abort silently: no release pulse.

Structure
REQ-032 Package key_pkg SHALL hold the FSM state enum and the default keycode constants KC_W=8'h1A, KC_S=8'h16, KC_A=8'h04, KC_D=8'h07.
REQ-033 Sub-module key_channel SHALL contain one channel's synchroniser, debouncer and FSM; key_event_decoder generates NUM_KEYS instances plus the keycode compare.

Verification
REQ-034 key_map={D,A,S,W}, keycode=32'h0000_1A00 at cycle 0 -> key_on[0]=1 from cycle 1, key_press[0] pulses at cycle 2, no other channel active.
REQ-035 KEY[1] low for 10 cycles, DEBOUNCE_CYCLES=16 -> no output change; held low for 20 cycles -> key_on[1] rises 18 cycles after the fall (2 sync + 16 debounce).
REQ-036 REPEAT_DELAY=8, REPEAT_RATE=3, channel 0 held for 20 cycles -> press at t, repeats at t+8, t+11, t+14, t+17, release one cycle after the drop.
REQ-037 Keycode 1A present for exactly one cycle -> key_press[0] and key_release[0] on consecutive cycles, no repeat.
REQ-038 Channel 2 in REPEAT, Reset_n pulsed low mid-count -> all outputs 0 immediately, no release pulse; key still held -> new key_press after reset.
REQ-039 btn_en[3]=0 with KEY[3] low -> key_on[3]=0; keycode 8'h07 in slot 3 with KEY[0] also pressed -> a single key_press[0].

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the key event decoder: channel FSM states,
// default HID keycodes and a counter-width helper.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_t;

    // USB HID usage codes for the default W/A/S/D mapping
    localparam logic [7:0] KC_W = 8'h1A;
    localparam logic [7:0] KC_S = 8'h16;
    localparam logic [7:0] KC_A = 8'h04;
    localparam logic [7:0] KC_D = 8'h07;

    // Bits needed to hold values 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One decoded key channel: pushbutton synchroniser and debouncer, key_on
// register, and the IDLE/HELD/REPEAT event FSM with its repeat counter.
// The FSM state is exposed on the state output for observation.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kc_hit,
    input  logic       key_n,
    input  logic       btn_en,
    output logic       key_on,
    output logic       key_press,
    output logic       key_release,
    output logic       key_repeat,
    output key_state_t state
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = cnt_width(RP_MAX);

    // Counter value on the cycle before the counter reaches DEBOUNCE_CYCLES-1
    localparam logic [DB_W-1:0] DB_FLIP    = DB_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

    logic [1:0]      sync_q;      // raw level, 1 = released
    logic            btn_stable;  // debounced raw level, 1 = released
    logic [DB_W-1:0] db_cnt;
    logic [RP_W-1:0] rp_cnt;
    logic            btn_hit;

    assign btn_hit = ~btn_stable & btn_en;

    // Synchronise the pushbutton and accept a new level only after it stays put
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            btn_stable <= 1'b1;
            db_cnt     <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            if (sync_q[1] == btn_stable) begin
                db_cnt <= '0;
            end else if ((DEBOUNCE_CYCLES == 1) || (db_cnt == DB_FLIP)) begin
                btn_stable <= sync_q[1];
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Combined held level: keyboard match or enabled debounced button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_on <= 1'b0;
        end else begin
            key_on <= kc_hit | btn_hit;
        end
    end

    // Event FSM: press on rise, release on fall (wins over a due repeat), timed repeats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rp_cnt      <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_on) begin
                        key_press <= 1'b1;
                        state     <= ST_HELD;
                        rp_cnt    <= '0;
                    end
                end
                ST_HELD: begin
                    if (!key_on) begin
                        key_release <= 1'b1;
                        state       <= ST_IDLE;
                        rp_cnt      <= '0;
                    end else if (REPEAT_DELAY == 0) begin
                        rp_cnt <= rp_cnt;
                    end else if (rp_cnt == DELAY_LAST) begin
                        key_repeat <= 1'b1;
                        state      <= ST_REPEAT;
                        rp_cnt     <= '0;
                    end else begin
                        rp_cnt <= rp_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!key_on) begin
                        key_release <= 1'b1;
                        state       <= ST_IDLE;
                        rp_cnt      <= '0;
                    end else if (rp_cnt == RATE_LAST) begin
                        key_repeat <= 1'b1;
                        rp_cnt     <= '0;
                    end else begin
                        rp_cnt <= rp_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    rp_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Key event decoder: matches HID keycode slots against a per-channel key map,
// merges with debounced pushbuttons and emits press/release/repeat events.
// dbg_state carries each channel's FSM state, two bits per channel.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int KC_SLOTS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [8*KC_SLOTS-1:0] keycode,
    input  logic [8*NUM_KEYS-1:0] key_map,
    input  logic [NUM_KEYS-1:0]   KEY,
    input  logic [NUM_KEYS-1:0]   btn_en,
    output logic [NUM_KEYS-1:0]   key_on,
    output logic [NUM_KEYS-1:0]   key_press,
    output logic [NUM_KEYS-1:0]   key_release,
    output logic [NUM_KEYS-1:0]   key_repeat,
    output logic [2*NUM_KEYS-1:0] dbg_state
);

    logic [NUM_KEYS-1:0] kc_hit;

    // A channel is hit when any slot carries its mapped code; code 00 is unmapped
    always_comb begin
        kc_hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            for (int j = 0; j < KC_SLOTS; j++) begin
                if ((key_map[8*i +: 8] != 8'h00) && (keycode[8*j +: 8] == key_map[8*i +: 8])) begin
                    kc_hit[i] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_state_t ch_state;

        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_channel (
            .clk         (Clk),
            .rst_n       (Reset_n),
            .kc_hit      (kc_hit[i]),
            .key_n       (KEY[i]),
            .btn_en      (btn_en[i]),
            .key_on      (key_on[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_repeat  (key_repeat[i]),
            .state       (ch_state)
        );

        assign dbg_state[2*i +: 2] = ch_state;
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: an event-level model predicts key_on and the
// three pulse outputs every cycle, and directed sequences pin exact timings.
module tb_key_event_decoder;
    import key_pkg::*;

    localparam int NK = 4;
    localparam int KS = 4;
    localparam int DB = 16;
    localparam int RD = 8;
    localparam int RR = 3;

    logic            Clk;
    logic            Reset_n;
    logic [8*KS-1:0] keycode;
    logic [8*NK-1:0] key_map;
    logic [NK-1:0]   KEY;
    logic [NK-1:0]   btn_en;
    logic [NK-1:0]   key_on;
    logic [NK-1:0]   key_press;
    logic [NK-1:0]   key_release;
    logic [NK-1:0]   key_repeat;
    logic [2*NK-1:0] dbg_state;

    key_event_decoder #(
        .NUM_KEYS        (NK),
        .KC_SLOTS        (KS),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .keycode     (keycode),
        .key_map     (key_map),
        .KEY         (KEY),
        .btn_en      (btn_en),
        .key_on      (key_on),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // model state
    logic [4*NK-1:0] exp_q[$];
    bit              m_hist [NK][DB+1];  // raw KEY samples, index 0 = newest
    logic [NK-1:0]   m_down;             // debounced button pressed
    logic [NK-1:0]   m_on1;              // key_on after the previous edge
    logic [NK-1:0]   m_on2;              // key_on two edges back
    int              m_pcyc [NK];        // edge of the current press

    function automatic logic model_kc_hit(input int i);
        logic [7:0] m;
        m = key_map[8*i +: 8];
        if (m == 8'h00) return 1'b0;
        for (int j = 0; j < KS; j++) begin
            if (keycode[8*j +: 8] == m) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [NK-1:0] e_on, e_pr, e_rl, e_rp;
        logic          all_diff;
        int            k;
        e_on = '0; e_pr = '0; e_rl = '0; e_rp = '0;
        cyc++;
        if (!Reset_n) begin
            m_down = '0;
            m_on1  = '0;
            m_on2  = '0;
            for (int i = 0; i < NK; i++)
                for (int h = 0; h <= DB; h++) m_hist[i][h] = 1'b1;
        end else begin
            for (int i = 0; i < NK; i++) begin
                for (int h = DB; h > 0; h--) m_hist[i][h] = m_hist[i][h-1];
                m_hist[i][0] = KEY[i];
                // events follow the key_on waveform of the two previous edges
                e_pr[i] = m_on1[i] & ~m_on2[i];
                e_rl[i] = ~m_on1[i] & m_on2[i];
                if (e_pr[i]) m_pcyc[i] = cyc;
                k = cyc - m_pcyc[i];
                e_rp[i] = m_on1[i] & m_on2[i] & (RD > 0) & (k >= RD) & (((k - RD) % RR) == 0);
                e_on[i] = model_kc_hit(i) | (m_down[i] & btn_en[i]);
                // the button flips once the synchronised view has disagreed long enough
                all_diff = 1'b1;
                for (int h = 2; h <= ((DB < 2) ? 2 : DB); h++)
                    if (m_hist[i][h] != m_down[i]) all_diff = 1'b0;
                if (all_diff) m_down[i] = ~m_down[i];
                m_on2[i] = m_on1[i];
                m_on1[i] = e_on[i];
            end
        end
        exp_q.push_back({e_on, e_pr, e_rl, e_rp});
    endtask

    // scoreboard: every edge, predict then compare 1 time unit later
    always @(posedge Clk) begin
        logic [4*NK-1:0] e;
        model_step();
        #1;
        if (exp_q.size() == 0) begin
            check("sb_queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_key_on",      key_on,      e[4*NK-1:3*NK]);
            check("sb_key_press",   key_press,   e[3*NK-1:2*NK]);
            check("sb_key_release", key_release, e[2*NK-1:NK]);
            check("sb_key_repeat",  key_repeat,  e[NK-1:0]);
            check("sb_pulse_exclusive",
                  (key_press & key_release) | (key_press & key_repeat) | (key_release & key_repeat), 0);
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // directed stimulus, driven on the falling edge
    initial begin
        int np0, np3, nr0, nr3;
        Reset_n = 1'b0;
        keycode = '0;
        key_map = {KC_D, KC_A, KC_S, KC_W};
        KEY     = '1;
        btn_en  = '1;
        repeat (3) @(negedge Clk);
        check("reset_key_on",      key_on,      0);
        check("reset_key_press",   key_press,   0);
        check("reset_key_release", key_release, 0);
        check("reset_key_repeat",  key_repeat,  0);
        check("reset_state",       dbg_state,   0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // W in slot 1 held for 20 cycles: press at 2, repeats 10/13/16/19, release 22
        keycode = 32'h0000_1A00;
        for (int k = 1; k <= 24; k++) begin
            @(negedge Clk);
            check("hold_on",      key_on,      (k <= 20) ? 1 : 0);
            check("hold_press",   key_press,   (k == 2) ? 1 : 0);
            check("hold_repeat",  key_repeat,  (k == 10 || k == 13 || k == 16 || k == 19) ? 1 : 0);
            check("hold_release", key_release, (k == 22) ? 1 : 0);
            if (k == 20) keycode = '0;
        end

        // one-cycle glitch: press then release on consecutive cycles
        keycode = 32'h1A00_0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            check("glitch_on",      key_on,      (k == 1) ? 1 : 0);
            check("glitch_press",   key_press,   (k == 2) ? 1 : 0);
            check("glitch_release", key_release, (k == 3) ? 1 : 0);
            check("glitch_repeat",  key_repeat,  0);
            if (k == 1) keycode = '0;
        end

        // all four channels together
        keycode = {KC_W, KC_S, KC_A, KC_D};
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            check("multi_on",      key_on,      (k <= 3) ? 4'hF : 4'h0);
            check("multi_press",   key_press,   (k == 2) ? 4'hF : 4'h0);
            check("multi_release", key_release, (k == 5) ? 4'hF : 4'h0);
            if (k == 3) keycode = '0;
        end

        // button bounce shorter than the debounce window is ignored
        KEY[1] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            check("bounce_on",    key_on,    0);
            check("bounce_press", key_press, 0);
            if (k == 10) KEY[1] = 1'b1;
        end

        // button held 25 cycles: on from 18 to 42, press 19, release 44
        KEY[1] = 1'b0;
        for (int k = 1; k <= 46; k++) begin
            @(negedge Clk);
            check("btn_on",      key_on,      (k >= 18 && k <= 42) ? 4'h2 : 4'h0);
            check("btn_press",   key_press,   (k == 19) ? 4'h2 : 4'h0);
            check("btn_repeat",  key_repeat,  (k >= 27 && k <= 42 && ((k - 27) % 3) == 0) ? 4'h2 : 4'h0);
            check("btn_release", key_release, (k == 44) ? 4'h2 : 4'h0);
            if (k == 25) KEY[1] = 1'b1;
        end

        // D mapped on channels 0 and 3, button 3 disabled, button 0 pressed too
        key_map = {KC_D, KC_A, KC_S, KC_D};
        btn_en  = 4'b0111;
        keycode = 32'h0700_0000;
        KEY[0]  = 1'b0;
        KEY[3]  = 1'b0;
        np0 = 0; np3 = 0; nr0 = 0; nr3 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            np0 += int'(key_press[0]);
            np3 += int'(key_press[3]);
            nr0 += int'(key_release[0]);
            nr3 += int'(key_release[3]);
            if (k == 30) keycode = '0;
        end
        check("dup_on3_btn_disabled", key_on[3], 0);
        check("dup_on0_by_button",    key_on[0], 1);
        check("dup_press0_count",     np0, 1);
        check("dup_press3_count",     np3, 1);
        check("dup_release0_count",   nr0, 0);
        check("dup_release3_count",   nr3, 1);
        KEY     = '1;
        key_map = {KC_D, KC_A, KC_S, KC_W};
        btn_en  = '1;
        repeat (40) @(negedge Clk);
        check("dup_idle_on", key_on, 0);

        // channel 2 in REPEAT, reset mid-count, key still held afterwards
        keycode = 32'h0000_0004;
        for (int k = 1; k <= 11; k++) begin
            @(negedge Clk);
            check("rst_pre_on",      key_on,      4'h4);
            check("rst_pre_press",   key_press,   (k == 2) ? 4'h4 : 4'h0);
            check("rst_pre_repeat",  key_repeat,  (k == 10) ? 4'h4 : 4'h0);
            check("rst_pre_release", key_release, 0);
        end
        check("rst_pre_state_repeat", dbg_state[5:4], 32'(ST_REPEAT));
        Reset_n = 1'b0;
        #1;
        check("rst_now_on",      key_on,      0);
        check("rst_now_press",   key_press,   0);
        check("rst_now_release", key_release, 0);
        check("rst_now_repeat",  key_repeat,  0);
        check("rst_now_state",   dbg_state,   0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            check("rst_post_on",      key_on,      4'h4);
            check("rst_post_press",   key_press,   (k == 2) ? 4'h4 : 4'h0);
            check("rst_post_release", key_release, 0);
        end
        keycode = '0;
        repeat (5) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
